// File: rtl/rf_pkg.sv
// rf_pkg: clear-FSM state type and flat-bus slicing helper for reg_file_mp.
package rf_pkg;
    typedef enum logic {RF_CLEAR, RF_READY} rf_state_e;
    function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction
endpackage

// File: rtl/rf_clear_ctrl.sv
// rf_clear_ctrl: sweeps every entry to zero after reset or on clr_req, then holds ready.
module rf_clear_ctrl
    import rf_pkg::*;
#(
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_idx
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    rf_state_e state;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RF_CLEAR;
            clr_idx <= '0;
        end else if (state == RF_CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
            state   <= (clr_idx == LAST) ? RF_READY : RF_CLEAR;
        end else if (clr_req) begin
            state   <= RF_CLEAR;
            clr_idx <= '0;
        end
    end
    assign ready  = (state == RF_READY);
    assign clr_we = (state == RF_CLEAR);
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with hardware clear sweep and optional zero entry.
// Define RF_BYPASS_EN for write-first forwarding of same-cycle writes to the read ports.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              ready,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NWR*DW-1:0] wr_data
);
    logic [DW-1:0] mem [DEPTH];
    logic          clr_we;
    logic [AW-1:0] clr_idx;
    rf_clear_ctrl #(.DEPTH(DEPTH)) u_clr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_req(clr_req),
        .ready  (ready),
        .clr_we (clr_we),
        .clr_idx(clr_idx)
    );
    // later ports overwrite earlier ones, so the highest-numbered port wins a conflict
    always_ff @(posedge clk) begin
        if (clr_we) mem[clr_idx] <= '0;
        else
            for (int w = 0; w < NWR; w++)
                if (wr_en[w] && !(ZERO_REG != 0 && wr_addr[slice_lo(w, AW) +: AW] == '0))
                    mem[wr_addr[slice_lo(w, AW) +: AW]] <= wr_data[slice_lo(w, DW) +: DW];
    end
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        assign a = rd_addr[slice_lo(p, AW) +: AW];
        always_comb begin
            d = mem[a];
`ifdef RF_BYPASS_EN
            for (int w = 0; w < NWR; w++)
                if (wr_en[w] && wr_addr[slice_lo(w, AW) +: AW] == a) d = wr_data[slice_lo(w, DW) +: DW];
`endif
        end
        assign rd_data[slice_lo(p, DW) +: DW] = (!ready || (ZERO_REG != 0 && a == '0)) ? '0 : d;
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed checks of clear sweep, read/write, conflicts, zero entry and bypass.
module tb_reg_file_mp;
    localparam int ZR = 1;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr_req = 1'b0;
    logic        ready;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    int total = 0;
    int bad = 0;

    reg_file_mp #(.DW(32), .DEPTH(32), .NRD(2), .NWR(2), .ZERO_REG(ZR)) dut (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1);
        wr_en = en;
        wr_addr = {a1, a0};
        wr_data = {d1, d0};
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd(5'd5, 5'd0);
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            #1;
            total++;
            if (ready !== (i == 32)) begin
                bad++;
                $display("FAIL reset_ready cycle=%0d got=%b exp=%b", i, ready, i == 32);
            end
            if (i == 16) begin
                total++;
                if (rd_data !== 64'h0) begin
                    bad++;
                    $display("FAIL reset_read got=%h exp=0", rd_data);
                end
            end
        end
        rd(5'd31, 5'd9);
        total++;
        if (rd_data !== 64'h0) begin
            bad++;
            $display("FAIL reset_cleared got=%h exp=0", rd_data);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        wr(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
        rd(5'd5, 5'd5);
        total++;
        if (rd_data[31:0] !== (BYP ? 32'hDEADBEEF : 32'h0)) begin
            bad++;
            $display("FAIL wr_same_cycle got=%h exp=%h", rd_data[31:0], BYP ? 32'hDEADBEEF : 32'h0);
        end
        @(negedge clk);
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(5'd5, 5'd5);
        total++;
        if (rd_data !== {2{32'hDEADBEEF}}) begin
            bad++;
            $display("FAIL wr_rd got=%h exp=%h", rd_data, {2{32'hDEADBEEF}});
        end
    endtask

    task automatic test_conflict();
        @(negedge clk);
        wr(2'b11, 5'd7, 32'h11, 5'd7, 32'h22);
        @(negedge clk);
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(5'd7, 5'd5);
        total++;
        if (rd_data !== {32'hDEADBEEF, 32'h22}) begin
            bad++;
            $display("FAIL conflict got=%h exp=%h", rd_data, {32'hDEADBEEF, 32'h22});
        end
        @(negedge clk);
        wr(2'b11, 5'd8, 32'h33, 5'd9, 32'h44);
        @(negedge clk);
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(5'd8, 5'd9);
        total++;
        if (rd_data !== {32'h44, 32'h33}) begin
            bad++;
            $display("FAIL dual_write got=%h exp=%h", rd_data, {32'h44, 32'h33});
        end
    endtask

    task automatic test_zero();
        logic [31:0] e;
        @(negedge clk);
        wr(2'b10, 5'd0, 32'h0, 5'd0, 32'hFFFFFFFF);
        rd(5'd0, 5'd0);
        e = (ZR != 0) ? 32'h0 : (BYP ? 32'hFFFFFFFF : 32'h0);
        total++;
        if (rd_data !== {2{e}}) begin
            bad++;
            $display("FAIL zero_same_cycle got=%h exp=%h", rd_data, {2{e}});
        end
        @(negedge clk);
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(5'd0, 5'd0);
        e = (ZR != 0) ? 32'h0 : 32'hFFFFFFFF;
        total++;
        if (rd_data !== {2{e}}) begin
            bad++;
            $display("FAIL zero_reg got=%h exp=%h", rd_data, {2{e}});
        end
    endtask

    task automatic test_bypass();
        logic [31:0] e;
        @(negedge clk);
        wr(2'b01, 5'd3, 32'h12345678, 5'd0, 32'h0);
        @(negedge clk);
        wr(2'b10, 5'd0, 32'h0, 5'd3, 32'hA5A5A5A5);
        rd(5'd3, 5'd3);
        e = BYP ? 32'hA5A5A5A5 : 32'h12345678;
        total++;
        if (rd_data !== {2{e}}) begin
            bad++;
            $display("FAIL bypass_same got=%h exp=%h", rd_data, {2{e}});
        end
        @(negedge clk);
        wr(2'b11, 5'd9, 32'h55, 5'd9, 32'h66);
        rd(5'd9, 5'd3);
        e = BYP ? 32'h66 : 32'h44;
        total++;
        if (rd_data !== {32'hA5A5A5A5, e}) begin
            bad++;
            $display("FAIL bypass_prio got=%h exp=%h", rd_data, {32'hA5A5A5A5, e});
        end
        @(negedge clk);
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(5'd9, 5'd3);
        total++;
        if (rd_data !== {32'hA5A5A5A5, 32'h66}) begin
            bad++;
            $display("FAIL bypass_after got=%h exp=%h", rd_data, {32'hA5A5A5A5, 32'h66});
        end
    endtask

    task automatic test_clear();
        @(negedge clk);
        clr_req = 1'b1;
        rd(5'd5, 5'd7);
        total++;
        if (ready !== 1'b1 || rd_data !== {32'h22, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL clr_pre got=%b/%h exp=1/%h", ready, rd_data, {32'h22, 32'hDEADBEEF});
        end
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            clr_req = (i == 16);
            if (i == 30) wr(2'b11, 5'd2, 32'hCAFE, 5'd4, 32'hBEEF);
            else wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
            #1;
            total++;
            if (ready !== (i == 33)) begin
                bad++;
                $display("FAIL clr_ready cycle=%0d got=%b exp=%b", i, ready, i == 33);
            end
            if (i == 10) begin
                total++;
                if (rd_data !== 64'h0) begin
                    bad++;
                    $display("FAIL clr_read got=%h exp=0", rd_data);
                end
            end
        end
        clr_req = 1'b0;
        rd(5'd2, 5'd4);
        total++;
        if (rd_data !== 64'h0) begin
            bad++;
            $display("FAIL clr_wr_dropped got=%h exp=0", rd_data);
        end
        rd(5'd5, 5'd3);
        total++;
        if (rd_data !== 64'h0) begin
            bad++;
            $display("FAIL clr_entries got=%h exp=0", rd_data);
        end
        rd(5'd7, 5'd9);
        total++;
        if (rd_data !== 64'h0) begin
            bad++;
            $display("FAIL clr_entries2 got=%h exp=0", rd_data);
        end
    endtask

    task automatic test_reset_mid_sweep();
        @(negedge clk);
        wr(2'b01, 5'd6, 32'h600D, 5'd0, 32'h0);
        @(negedge clk);
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            #1;
            total++;
            if (ready !== (i == 32)) begin
                bad++;
                $display("FAIL rst_mid_ready cycle=%0d got=%b exp=%b", i, ready, i == 32);
            end
        end
        @(negedge clk);
        wr(2'b10, 5'd0, 32'h0, 5'd12, 32'h0BADF00D);
        @(negedge clk);
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(5'd12, 5'd6);
        total++;
        if (rd_data !== {32'h0, 32'h0BADF00D}) begin
            bad++;
            $display("FAIL rst_mid_after got=%h exp=%h", rd_data, {32'h0, 32'h0BADF00D});
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_conflict();
        test_zero();
        test_bypass();
        test_clear();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
